mac_rr_scheduler: RTL
=====================

# mac_rr_scheduler

Round-robin scheduler that shares one fixed-latency radix-8 Booth multiplier among NCH operand streams. It performs per-channel 40-bit accumulation over frames of FRAME_LEN products and returns one truncated 27-bit result per channel per frame. It sits between the operand producers and the multiplier datapath, replacing per-channel MAC instances.

## Interface
- NCH, 4: number of requester channels, 2..8
- FRAME_LEN, 256: products accumulated per result, 1..511 (511 guarantees no 40-bit overflow)
- MULT_LAT, 2: multiplier latency in clocks, from mul_a/mul_b sampled to mul_p valid, ≥1
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high (fixed)
- clr  in  1  synchronous flush of all channels
- req_valid  in  NCH  per-channel operand valid
- req_ready  out  NCH  per-channel accept, one-hot or zero
- req_a  in  NCH×16  signed multiplier operands, packed [NCH-1:0][15:0]
- req_b  in  NCH×16  signed multiplicand operands, same packing
- mul_a, mul_b  out  16 each  operands to the multiplier
- mul_vld  out  1  operand pair issued this cycle
- mul_p  in  33  signed product, valid MULT_LAT cycles after issue
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_ch  out  $clog2(NCH)  channel of the presented result
- res_data  out  27  signed result
- busy  out  1  any product in flight or any result pending

## Operation
- **Eligibility:** channel c is eligible when req_valid[c]=1, issue_cnt[c]<FRAME_LEN, done[c]=0, and clr=0.
- **Arbitration:** round-robin over eligible channels, starting at ptr. req_ready is combinational from req_valid. After a grant to channel c, ptr becomes (c+1) mod NCH. At most one grant per cycle.
- **Issue:** on a grant, register req_a[c]/req_b[c] to mul_a/mul_b, set mul_vld=1, increment issue_cnt[c], and push {valid, c} into a MULT_LAT-deep tag shift register.
- **Accumulate:** when the tag pipe output is valid, acc[tag] += sign-extended mul_p (40-bit). After accumulating the last product, when acc_cnt reaches FRAME_LEN, set done[tag].
- **Result selection:** the lowest-index channel with done set is presented. res_data = acc[39:13]. While res_valid && !res_ready, res_ch and res_data hold stable.
- **Result consumption:** on res_valid && res_ready, clear acc, issue_cnt, acc_cnt and done for that channel. The channel becomes eligible again in the same cycle as the handshake.
- **Stall guarantee:** a channel stays blocked from FRAME_LEN issue until its result is read, so accumulation never collides with a pending result.
- **clr:** clears all acc, counters, done flags, tag-pipe valid bits, and ptr. In-flight products are discarded. req_ready=0 during the clr cycle.

## Timing
- **Reset values:** all outputs 0 (req_ready, mul_a, mul_b, mul_vld, res_valid, res_ch, res_data, busy). ptr=0, all state cleared. Asserting rst mid-frame discards in-flight products.
- **Handshake at cycle t:** mul_vld=1 at t+1; mul_p is sampled at t+1+MULT_LAT; acc updates at the end of that cycle.
- **Result latency:** after the last handshake of a frame, res_valid rises in cycle t+MULT_LAT+2.
- **Throughput:** one product per clock aggregate. With all channels valid, each channel gets one grant per NCH cycles.
- **busy:** 1 whenever any tag valid bit or any done flag is set.

## Configuration
- MAC_SCHED_ROUND_EN defined: res_data = (acc + 2^12)[39:13], i.e. round half up. Overflow is impossible for FRAME_LEN ≤ 511.
- Not defined: res_data = acc[39:13], i.e. truncation toward −∞.

## Structure
- Package mac_pkg holds:
  - constants OP_W=16, PROD_W=33, ACC_W=40, RES_W=27, RES_LSB=13
  - typedefs op_t, prod_t, acc_t, res_t
- Sub-module rr_arbiter (parameter N) contains the pointer and the one-hot grant; the scheduler instantiates it once.
- The tag pipe, accumulators and result mux live in the top.

## Test plan
- **Reset:** assert rst mid-frame with products in flight → all outputs 0 immediately; the following frame result excludes pre-reset samples.
- **Single frame:** FRAME_LEN=4, ch0 sends A=16384,B=16384 ×4 → exactly one result, res_ch=0, res_data=131072. Repeat with A=−16384 → res_data=−131072.
- **Fairness:** NCH=4, all req_valid held high → grant sequence 0,1,2,3,0,…; each req_ready pulses once per 4 cycles.
- **Backpressure:** FRAME_LEN=4, res_ready=0, ch1 and ch2 complete frames → ch1 and ch2 req_ready stay 0. Raise res_ready → ch1 result first, then ch2 the next cycle; both channels resume issuing.
- **clr mid-frame:** ch0 issues 2 samples of 100×100, assert clr while they are in flight, then issue 4 samples of 16384×16384 → res_data=131072 with no contribution from the flushed samples.
- **Rounding:** FRAME_LEN=4, ch0 sends A=1024,B=1 ×4 (acc=4096) → res_data=1 with MAC_SCHED_ROUND_EN, 0 without.

Source files
------------

// File: rtl/mac_rr_scheduler_pkg.sv
// Shared widths and types for the round-robin MAC scheduler.
// Products are 33-bit signed, accumulators 40-bit, results acc[39:13].
package mac_pkg;

  localparam int OP_W    = 16;
  localparam int PROD_W  = 33;
  localparam int ACC_W   = 40;
  localparam int RES_W   = 27;
  localparam int RES_LSB = 13;

  typedef logic signed [OP_W-1:0]   op_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [RES_W-1:0]  res_t;

  // Channel field is sized for the largest supported NCH (8).
  typedef struct packed {
    logic       vld;
    logic [2:0] ch;
  } tag_t;

endpackage

// File: rtl/mac_rr_scheduler_if.sv
// Operand request and result handshake bundle of the MAC scheduler.
// slave = scheduler side, master = producer/consumer side.
interface mac_rr_scheduler_if
  import mac_pkg::*;
#(
  parameter int NCH = 4
) ();

  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0] req_valid;
  logic [NCH-1:0] req_ready;
  op_t  [NCH-1:0] req_a;
  op_t  [NCH-1:0] req_b;

  logic            res_valid;
  logic            res_ready;
  logic [CH_W-1:0] res_ch;
  res_t            res_data;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_ch, res_data
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_ch, res_data
  );

endinterface

// File: rtl/mac_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves past the winner.
// i_clr returns the pointer to channel 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic                 o_gnt_vld,
  output logic [$clog2(N)-1:0] o_gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_idx;
  logic          w_vld;

  always_comb begin
    w_vld  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    o_gnt  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = (int'(r_ptr) + i >= N) ? IW'(int'(r_ptr) + i - N) : IW'(int'(r_ptr) + i);
      if (!w_vld && i_req[w_cand]) begin
        w_vld = 1'b1;
        w_idx = w_cand;
      end
    end
    if (w_vld) o_gnt[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (w_vld) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
    end
  end

  assign o_gnt_vld = w_vld;
  assign o_gnt_idx = w_idx;

endmodule

// File: rtl/mac_rr_scheduler.sv
// Shares one fixed-latency multiplier among NCH streams, accumulating FRAME_LEN products per result.
// Define MAC_SCHED_ROUND_EN for round-half-up results; default truncates.
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 256,
  parameter int MULT_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  mac_rr_scheduler_if.slave   if_s,
  output op_t                 o_mul_a,
  output op_t                 o_mul_b,
  output logic                o_mul_vld,
  input  prod_t               i_mul_p,
  output logic                o_busy
);

  localparam int CH_W  = $clog2(NCH);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  acc_t             r_acc       [NCH];
  logic [CNT_W-1:0] r_issue_cnt [NCH];
  logic [CNT_W-1:0] r_acc_cnt   [NCH];
  logic [NCH-1:0]   r_done;
  tag_t             r_tag       [MULT_LAT+1];
  op_t              r_mul_a;
  op_t              r_mul_b;
  logic             r_mul_vld;

  logic [NCH-1:0]  w_elig;
  logic [NCH-1:0]  w_gnt;
  logic            w_gnt_vld;
  logic [CH_W-1:0] w_gnt_idx;
  logic [NCH-1:0]  w_cons;
  logic [NCH-1:0]  w_hit;
  logic            w_res_valid;
  logic            w_consume;
  logic [CH_W-1:0] w_res_ch;
  acc_t            w_sel_acc;
  acc_t            w_res_full;
  acc_t            w_prod_ext;
  logic            w_busy;

  always_comb begin
    w_res_ch = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (r_done[c]) w_res_ch = CH_W'(c);
    end
  end

  assign w_res_valid = |r_done;
  assign w_consume   = w_res_valid && if_s.res_ready;

  // A channel whose result is being read this cycle may issue in the same cycle.
  always_comb begin
    w_cons = '0;
    w_hit  = '0;
    w_elig = '0;
    for (int c = 0; c < NCH; c++) begin
      w_cons[c] = w_consume && (w_res_ch == CH_W'(c));
      w_hit[c]  = r_tag[MULT_LAT].vld && (r_tag[MULT_LAT].ch == 3'(c));
      w_elig[c] = if_s.req_valid[c] && !i_clr && !rst &&
                  (((r_issue_cnt[c] < FRAME_CNT) && !r_done[c]) || w_cons[c]);
    end
  end

  rr_arbiter #(
    .N (NCH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (i_clr),
    .i_req     (w_elig),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_vld <= 1'b0;
    end else begin
      r_mul_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_mul_a <= if_s.req_a[w_gnt_idx];
        r_mul_b <= if_s.req_b[w_gnt_idx];
      end
    end
  end

  // Stage 0 lines up with mul_vld; the last stage lines up with mul_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MULT_LAT; i++) r_tag[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i <= MULT_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_gnt_vld, ch: 3'(w_gnt_idx)};
      for (int i = 1; i <= MULT_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_prod_ext = {{(ACC_W - PROD_W){i_mul_p[PROD_W-1]}}, i_mul_p};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_acc[c]       <= '0;
        r_issue_cnt[c] <= '0;
        r_acc_cnt[c]   <= '0;
      end
    end else if (i_clr) begin
      r_done <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_acc[c]       <= '0;
        r_issue_cnt[c] <= '0;
        r_acc_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_cons[c]) begin
          r_acc[c]     <= '0;
          r_acc_cnt[c] <= '0;
          r_done[c]    <= 1'b0;
        end else if (w_hit[c]) begin
          r_acc[c]     <= r_acc[c] + w_prod_ext;
          r_acc_cnt[c] <= r_acc_cnt[c] + CNT_ONE;
          if (r_acc_cnt[c] == FRAME_LAST) r_done[c] <= 1'b1;
        end
        if (w_cons[c]) begin
          r_issue_cnt[c] <= w_gnt[c] ? CNT_ONE : '0;
        end else if (w_gnt[c]) begin
          r_issue_cnt[c] <= r_issue_cnt[c] + CNT_ONE;
        end
      end
    end
  end

  assign w_sel_acc = r_acc[w_res_ch];

`ifdef MAC_SCHED_ROUND_EN
  assign w_res_full = w_sel_acc + acc_t'(1 << (RES_LSB - 1));
`else
  assign w_res_full = w_sel_acc;
`endif

  always_comb begin
    w_busy = |r_done;
    for (int i = 0; i <= MULT_LAT; i++) w_busy = w_busy | r_tag[i].vld;
  end

  assign if_s.req_ready = w_gnt;
  assign if_s.res_valid = w_res_valid;
  assign if_s.res_ch    = w_res_ch;
  assign if_s.res_data  = w_res_full[ACC_W-1:RES_LSB];
  assign o_mul_a        = r_mul_a;
  assign o_mul_b        = r_mul_b;
  assign o_mul_vld      = r_mul_vld;
  assign o_busy         = w_busy;

endmodule
